// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants, FSM encoding and small state/pointer helpers
// used by the survivor memory and its traceback reader.
package viterbi_pkg;

    localparam int K     = 5;
    localparam int M     = K - 1;
    localparam int S     = 1 << M;
    localparam int D     = 10;
    localparam int PTR_W = $clog2(D);
    localparam int ST_W  = $clog2(S);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACE = 2'd1,
        OUT   = 2'd2
    } tb_state_e;

    // Newest bit lives in the MSB, so stepping back in time shifts toward the MSB.
    function automatic logic [M-1:0] pred(input logic [M-1:0] s, input logic b);
        return {s[M-2:0], b};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == {PTR_W{1'b0}}) ? PTR_W'(D - 1) : p - PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(D - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/traceback_unit_if.sv
// Bundle of start request, survivor-memory read port and decoded-bit stream
// between the traceback unit and its neighbours.
interface traceback_unit_if;
    import viterbi_pkg::*;

    logic             tb_start;
    logic [PTR_W-1:0] tb_ptr;
    logic [M-1:0]     tb_state;
    logic             busy;
    logic [ST_W-1:0]  rd_state;
    logic [PTR_W-1:0] rd_time;
    logic             surv_bit;
    logic             dec_bit;
    logic             dec_valid;
    logic             dec_ready;

    modport master (
        output tb_start, tb_ptr, tb_state, surv_bit, dec_ready,
        input  busy, rd_state, rd_time, dec_bit, dec_valid
    );

    modport slave (
        input  tb_start, tb_ptr, tb_state, surv_bit, dec_ready,
        output busy, rd_state, rd_time, dec_bit, dec_valid
    );

endinterface

// File: rtl/traceback_unit.sv
// Survivor-memory reader: walks L decision rows backwards from the newest row
// and best state, then offers one decoded bit on a valid/ready handshake.
module traceback_unit
    import viterbi_pkg::*;
#(
    parameter int L = 8
) (
    input  logic             clk,
    input  logic             rst,
    traceback_unit_if.slave  tif
);

    localparam int STEP_W = $clog2(L + 1);

    tb_state_e         state_q, state_d;
    logic [M-1:0]      cur_q, cur_d;
    logic [PTR_W-1:0]  tptr_q, tptr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              dec_bit_q, dec_bit_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_q     <= {M{1'b0}};
            tptr_q    <= {PTR_W{1'b0}};
            step_q    <= {STEP_W{1'b0}};
            dec_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            tptr_q    <= tptr_d;
            step_q    <= step_d;
            dec_bit_q <= dec_bit_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tptr_d    = tptr_q;
        step_d    = step_q;
        dec_bit_d = dec_bit_q;
        case (state_q)
            IDLE: begin
                if (tif.tb_start) begin
                    state_d = TRACE;
                    cur_d   = tif.tb_state;
                    tptr_d  = tif.tb_ptr;
                    step_d  = {STEP_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            TRACE: begin
                cur_d  = pred(cur_q, tif.surv_bit);
                tptr_d = ptr_dec(tptr_q);
                step_d = step_q + STEP_W'(1);
                // The decoded bit is captured once, so it stays stable while stalled.
                if (step_q == STEP_W'(L - 1)) begin
                    state_d   = OUT;
                    dec_bit_d = cur_d[M-1];
                end else begin
                    state_d = TRACE;
                end
            end
            OUT: begin
                if (tif.dec_ready) begin
                    state_d   = IDLE;
                    dec_bit_d = 1'b0;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tif.busy      = (state_q != IDLE);
    assign tif.dec_valid = (state_q == OUT);
    assign tif.dec_bit   = dec_bit_q;
    assign tif.rd_state  = (state_q == TRACE) ? cur_q  : {ST_W{1'b0}};
    assign tif.rd_time   = (state_q == TRACE) ? tptr_q : {PTR_W{1'b0}};

endmodule
